// File: rtl/rx_frame_ctrl_pkg.sv
// Shared types and constants for the MAC RX frame sequencer.
package rx_frame_ctrl_pkg;

  localparam int HDR_BYTES = 14;
  localparam int MAC_W     = 48;
  localparam int MAC_BYTES = MAC_W / 8;
  localparam int HDR_CNT_W = 4;
  localparam int PLD_CNT_W = 11;

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    HEADER,
    PAYLOAD,
    DROP
  } rx_state_t;

  typedef struct packed {
    logic [MAC_W-1:0] dst_mac;
    logic [MAC_W-1:0] src_mac;
    logic [15:0]      eth_type;
  } rx_hdr_t;

endpackage

// File: rtl/rx_frame_ctrl_if.sv
// 8-bit AXI-Stream byte channel from the MAC receive path.
interface rx_frame_ctrl_if;

  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, tvalid, tlast, tuser);
  modport slave  (input  tdata, tvalid, tlast, tuser);

endinterface

// File: rtl/rx_stat_cnt.sv
// Saturating event counter for frame statistics.
module rx_stat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/rx_frame_ctrl.sv
// Splits MAC RX frames into a 14-byte header shift stream and a payload stream.
// Optional destination address filtering is enabled by defining RX_ADDR_FILTER_EN.
module rx_frame_ctrl
  import rx_frame_ctrl_pkg::*;
#(
  parameter int MAX_PLD = 1500,
  parameter int CNT_W   = 16
`ifdef RX_ADDR_FILTER_EN
  ,
  parameter logic [MAC_W-1:0] LOCAL_MAC = 48'h00_0A_35_01_02_03
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  rx_frame_ctrl_if.slave     rx_axis,
  output logic [7:0]         r_data,
  output logic               header_en,
  output logic               hdr_done,
  output logic [7:0]         pld_data,
  output logic               pld_valid,
  output logic               pld_last,
  output logic               frame_good,
  output logic               frame_bad,
  output logic [CNT_W-1:0]   good_cnt,
  output logic [CNT_W-1:0]   bad_cnt
);

  rx_state_t              state_reg, state_next;
  logic [HDR_CNT_W-1:0]   hdr_cnt_reg, hdr_cnt_next;
  logic [PLD_CNT_W-1:0]   pld_cnt_reg, pld_cnt_next;
  logic [7:0]             r_data_reg, r_data_next;
  logic [7:0]             pld_data_reg, pld_data_next;
  logic                   header_en_reg, header_en_next;
  logic                   hdr_done_reg, hdr_done_next;
  logic                   pld_valid_reg, pld_valid_next;
  logic                   pld_last_reg, pld_last_next;
  logic                   frame_good_reg, frame_good_next;
  logic                   frame_bad_reg, frame_bad_next;

  logic                   addr_miss;
  logic                   drop_bad;

`ifdef RX_ADDR_FILTER_EN
  logic [7:0] mac_hit;
  logic [2:0] mac_idx;
  logic       in_dst;
  logic       loc_ok_reg, bc_ok_reg, drop_bad_reg;

  for (genvar gi = 0; gi < 8; gi++) begin : g_mac_cmp
    if (gi < MAC_BYTES) begin : g_byte
      assign mac_hit[gi] = (rx_axis.tdata == LOCAL_MAC[MAC_W-1-8*gi -: 8]);
    end else begin : g_pad
      assign mac_hit[gi] = 1'b0;
    end
  end

  assign in_dst  = (state_reg == IDLE) ||
                   ((state_reg == HEADER) && (hdr_cnt_reg < HDR_CNT_W'(MAC_BYTES)));
  assign mac_idx = (state_reg == IDLE) ? 3'd0 : hdr_cnt_reg[2:0];

  // Both match flags restart on byte 0; a frame survives if either stays set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loc_ok_reg   <= 1'b0;
      bc_ok_reg    <= 1'b0;
      drop_bad_reg <= 1'b0;
    end else begin
      if (rx_axis.tvalid && in_dst) begin
        loc_ok_reg <= mac_hit[mac_idx] && ((state_reg == IDLE) || loc_ok_reg);
        bc_ok_reg  <= (rx_axis.tdata == 8'hFF) && ((state_reg == IDLE) || bc_ok_reg);
      end
      if ((state_reg == HEADER) && (state_next == DROP)) begin
        drop_bad_reg <= 1'b1;
      end else if (state_next == IDLE) begin
        drop_bad_reg <= 1'b0;
      end
    end
  end

  assign addr_miss = !(loc_ok_reg || bc_ok_reg);
  assign drop_bad  = drop_bad_reg;
`else
  assign addr_miss = 1'b0;
  assign drop_bad  = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    hdr_cnt_next    = hdr_cnt_reg;
    pld_cnt_next    = pld_cnt_reg;
    r_data_next     = r_data_reg;
    pld_data_next   = pld_data_reg;
    header_en_next  = 1'b0;
    hdr_done_next   = 1'b0;
    pld_valid_next  = 1'b0;
    pld_last_next   = 1'b0;
    frame_good_next = 1'b0;
    frame_bad_next  = 1'b0;

    if (rx_axis.tvalid) begin
      unique case (state_reg)
        SYNC: begin
        end
        IDLE: begin
          header_en_next = 1'b1;
          r_data_next    = rx_axis.tdata;
          hdr_cnt_next   = HDR_CNT_W'(1);
          if (rx_axis.tlast) begin
            frame_bad_next = 1'b1;
          end else begin
            state_next = HEADER;
          end
        end
        HEADER: begin
          header_en_next = 1'b1;
          r_data_next    = rx_axis.tdata;
          hdr_cnt_next   = hdr_cnt_reg + 1'b1;
          if (hdr_cnt_reg == HDR_CNT_W'(HDR_BYTES - 1)) begin
            hdr_done_next = 1'b1;
            pld_cnt_next  = '0;
            if (rx_axis.tlast) begin
              frame_good_next = !(rx_axis.tuser || addr_miss);
              frame_bad_next  = rx_axis.tuser || addr_miss;
              state_next      = IDLE;
            end else begin
              state_next = addr_miss ? DROP : PAYLOAD;
            end
          end else if (rx_axis.tlast) begin
            frame_bad_next = 1'b1;
            state_next     = IDLE;
          end
        end
        PAYLOAD: begin
          // An oversize frame is rejected even if its excess byte carries tlast.
          if (pld_cnt_reg == PLD_CNT_W'(MAX_PLD)) begin
            frame_bad_next = 1'b1;
            state_next     = rx_axis.tlast ? IDLE : DROP;
          end else begin
            pld_valid_next = 1'b1;
            pld_data_next  = rx_axis.tdata;
            pld_last_next  = rx_axis.tlast;
            pld_cnt_next   = pld_cnt_reg + 1'b1;
            if (rx_axis.tlast) begin
              frame_good_next = !rx_axis.tuser;
              frame_bad_next  = rx_axis.tuser;
              state_next      = IDLE;
            end
          end
        end
        DROP: begin
          if (rx_axis.tlast) begin
            frame_bad_next = drop_bad;
            state_next     = IDLE;
          end
        end
        default: state_next = SYNC;
      endcase
    end else if (state_reg == SYNC) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= SYNC;
      hdr_cnt_reg    <= '0;
      pld_cnt_reg    <= '0;
      r_data_reg     <= '0;
      pld_data_reg   <= '0;
      header_en_reg  <= 1'b0;
      hdr_done_reg   <= 1'b0;
      pld_valid_reg  <= 1'b0;
      pld_last_reg   <= 1'b0;
      frame_good_reg <= 1'b0;
      frame_bad_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hdr_cnt_reg    <= hdr_cnt_next;
      pld_cnt_reg    <= pld_cnt_next;
      r_data_reg     <= r_data_next;
      pld_data_reg   <= pld_data_next;
      header_en_reg  <= header_en_next;
      hdr_done_reg   <= hdr_done_next;
      pld_valid_reg  <= pld_valid_next;
      pld_last_reg   <= pld_last_next;
      frame_good_reg <= frame_good_next;
      frame_bad_reg  <= frame_bad_next;
    end
  end

  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign cnt_inc = {frame_bad_next, frame_good_next};

  for (genvar gi = 0; gi < 2; gi++) begin : g_stat
    rx_stat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cnt_inc[gi]),
      .cnt   (cnt_val[gi])
    );
  end

  assign good_cnt   = cnt_val[0];
  assign bad_cnt    = cnt_val[1];
  assign r_data     = r_data_reg;
  assign header_en  = header_en_reg;
  assign hdr_done   = hdr_done_reg;
  assign pld_data   = pld_data_reg;
  assign pld_valid  = pld_valid_reg;
  assign pld_last   = pld_last_reg;
  assign frame_good = frame_good_reg;
  assign frame_bad  = frame_bad_reg;

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
- Receive-side frame sequencer between the tri-mode Ethernet MAC RX AXI-Stream (8-bit) and header_reg / payload consumers.
- Counts the first 14 bytes of each frame (dest MAC, src MAC, ethertype) and drives r_data/header_en so header_reg assembles the header.
- Forwards the remaining bytes as a payload stream and classifies each frame as good or bad.

Parameters:
- MAX_PLD, 1500, maximum accepted payload bytes; larger frames are dropped.
- CNT_W, 16, width of the frame statistics counters.
- LOCAL_MAC, 48'h00_0A_35_01_02_03, station address used only when RX_ADDR_FILTER_EN is defined.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rx_axis_tdata  in  8  MAC RX byte
- rx_axis_tvalid  in  1  byte valid; may gap mid-frame at 10/100 rates
- rx_axis_tlast  in  1  last byte of frame
- rx_axis_tuser  in  1  MAC bad-frame flag, sampled with tlast
- r_data  out  8  header byte to header_reg
- header_en  out  1  header_reg shift enable
- hdr_done  out  1  1-cycle pulse: 14th header byte presented
- pld_data  out  8  payload byte
- pld_valid  out  1  payload byte valid
- pld_last  out  1  last payload byte
- frame_good  out  1  1-cycle pulse at end of accepted frame
- frame_bad  out  1  1-cycle pulse at end of rejected frame
- good_cnt  out  CNT_W  good frames, saturating
- bad_cnt  out  CNT_W  bad frames, saturating

Behaviour:
- Reset: rst_n is synchronous, active-low, clock clk.
  - All outputs and counters reset to 0.
  - State resets to SYNC.
- Latency: every output is registered; each output reflects the input beat one cycle earlier. header_reg therefore holds the byte two cycles after the input beat.
- Beats: only cycles with rx_axis_tvalid=1 are processed. Gap cycles hold the state and drive header_en, pld_valid and all pulses to 0.
- States:
  - SYNC: discard input. Move to IDLE after one cycle with tvalid=0. This prevents misparsing when reset is released mid-frame.
  - IDLE: on a beat, byte 0 goes to the header (header_en=1), hdr_cnt=1, move to HEADER. A beat with tlast here is a 1-byte runt: frame_bad, stay in IDLE.
  - HEADER: each beat sets header_en=1 and increments hdr_cnt.
    - On the 14th byte (hdr_cnt==13 before increment), pulse hdr_done and move to PAYLOAD.
    - tlast before the 14th byte: frame_bad (runt), go to IDLE.
    - tlast on the 14th byte: hdr_done plus frame_good (or frame_bad if tuser=1), go to IDLE. A zero-payload frame is legal.
  - PAYLOAD: each beat sets pld_valid=1, pld_data=tdata, pld_last=tlast, and increments pld_cnt (11 bits).
    - tlast: frame_good, or frame_bad if tuser=1. Go to IDLE.
    - Beat number MAX_PLD+1 without tlast: frame_bad immediately, suppress pld_valid, go to DROP. The consumer must discard a payload not ended by pld_last and treat frame_bad as an abort.
  - DROP: discard beats until tlast, then go to IDLE. No further pulse is issued for that frame.
- Mutual exclusion: frame_good and frame_bad are never asserted together. The counters increment on the same edge the pulse is registered, and saturate at all-ones.
- Simultaneous reset with a beat: reset wins; the beat is lost.

Optional Feature:
- Macro RX_ADDR_FILTER_EN.
- Defined: header bytes 0..5 are compared on the fly against LOCAL_MAC (MSB byte first) and against broadcast FF:FF:FF:FF:FF:FF.
  - A mismatch with both sets a sticky miss flag.
  - At hdr_done with miss=1: pld_valid is suppressed, state goes to DROP (or IDLE if tlast), and frame_bad pulses once at the frame's tlast.
  - header_en still shifts all 14 bytes.
- Undefined: all destinations are accepted; no comparator logic is present.

Decomposition:
- Package defines (existing) receives:
  - HDR_BYTES=14 and MAC_W=48
  - the rx_state_t enum {SYNC, IDLE, HEADER, PAYLOAD, DROP}
  - the existing 112-bit header typedef, unchanged
- Natural sub-module: rx_stat_cnt, a saturating CNT_W counter with inc input, instantiated twice for good_cnt and bad_cnt.

Test Plan:
- Reset then 14 header bytes 0x01..0x0E plus 4 payload bytes 0xA0..0xA3 with tlast -> 14 header_en pulses, hdr_done on byte 0x0E, pld_valid x4, pld_last with 0xA3, frame_good, good_cnt=1.
- Same frame with tvalid low on alternate cycles -> identical output sequence spaced out, no spurious enables.
- 10-byte frame ending in tlast -> no hdr_done, frame_bad, bad_cnt=1. A 14-byte frame with tuser=1 on tlast -> hdr_done and frame_bad.
- Payload of MAX_PLD+5 bytes -> frame_bad on beat MAX_PLD+1, no pld_last, next frame parsed normally.
- rst_n pulsed low during byte 20 of a frame -> SYNC discards the remainder. The following frame is received good after a tvalid-low cycle.
- RX_ADDR_FILTER_EN: dest 00:0A:35:01:02:03 accepted, FF:FF:FF:FF:FF:FF accepted, 00:0A:35:01:02:04 -> no pld_valid, frame_bad at tlast.
